// File: rtl/tvip_axi_burst_sequencer_if.sv
// Command-in / beat-out bundle for tvip_axi_burst_sequencer.
// master: command source and beat consumer; slave: the sequencer itself.
interface tvip_axi_burst_sequencer_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ID_WIDTH      = 4
);
  localparam int unsigned NB = DATA_WIDTH / 8;

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [ID_WIDTH-1:0]      cmd_id;
  logic [ADDRESS_WIDTH-1:0] cmd_addr;
  logic [7:0]               cmd_len;
  logic [2:0]               cmd_size;
  logic [1:0]               cmd_burst;

  logic                     beat_valid;
  logic                     beat_ready;
  logic [ID_WIDTH-1:0]      beat_id;
  logic [ADDRESS_WIDTH-1:0] beat_addr;
  logic [7:0]               beat_index;
  logic [NB-1:0]            beat_mask;
  logic                     beat_last;
  logic                     busy;

  modport master (
    output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    input  cmd_ready, beat_valid, beat_id, beat_addr, beat_index, beat_mask, beat_last, busy
  );

  modport slave (
    input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    output cmd_ready, beat_valid, beat_id, beat_addr, beat_index, beat_mask, beat_last, busy
  );
endinterface

// File: rtl/tvip_axi_burst_sequencer.sv
// Expands one AXI AW/AR command into per-beat address, byte-lane mask and last flag.
// Define TVIP_AXI_BURST_SEQUENCER_4KB_CHECK_EN to add the err_4kb protocol-check pulse.
module tvip_axi_burst_sequencer #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ID_WIDTH      = 4
) (
  input  logic                      aclk,
  input  logic                      areset_n,
  tvip_axi_burst_sequencer_if.slave bus
`ifdef TVIP_AXI_BURST_SEQUENCER_4KB_CHECK_EN
  ,
  output logic                      err_4kb
`endif
);
  localparam int unsigned AW     = ADDRESS_WIDTH;
  localparam int unsigned NB     = DATA_WIDTH / 8;
  localparam int unsigned NB_LOG = $clog2(NB);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]          state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                beat_valid_q, beat_valid_d;
  logic                busy_q, busy_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [7:0]          index_q, index_d;
  logic [NB-1:0]       mask_q, mask_d;
  logic                last_q, last_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          mode_q, mode_d;
  logic [AW-1:0]       wrap_base_q, wrap_base_d;
  logic [AW-1:0]       wrap_total_q, wrap_total_d;

  logic                accept;
  logic                beat_hs;
  logic [2:0]          cmd_sz;
  logic [AW-1:0]       cmd_s;
  logic [AW-1:0]       cmd_total;
  logic                wrap_legal;
  logic [1:0]          cmd_mode;
  logic [AW-1:0]       nxt_addr;
  logic [7:0]          nxt_index;

  // Oversize transfers are clamped to the bus width.
  function automatic logic [2:0] eff_size(input logic [2:0] size);
    if (32'(size) > NB_LOG) return 3'(NB_LOG);
    return size;
  endfunction

  function automatic logic [AW-1:0] size_bytes(input logic [2:0] sz);
    return AW'(1) << sz;
  endfunction

  // Lanes from the (possibly unaligned) start byte up to the end of the aligned container.
  function automatic logic [NB-1:0] lane_mask(input logic [AW-1:0] addr, input logic [2:0] sz);
    logic [AW-1:0] s;
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;
    logic [NB-1:0] m;
    s  = size_bytes(sz);
    lo = addr & AW'(NB - 1);
    hi = ((addr & ~(s - AW'(1))) & AW'(NB - 1)) + s - AW'(1);
    m  = '0;
    for (int unsigned i = 0; i < NB; i++) m[i] = (AW'(i) >= lo) && (AW'(i) <= hi);
    return m;
  endfunction

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [2:0] sz,
                                               input logic [1:0] mode, input logic [AW-1:0] base,
                                               input logic [AW-1:0] total);
    logic [AW-1:0] s;
    logic [AW-1:0] nxt;
    s   = size_bytes(sz);
    nxt = (addr & ~(s - AW'(1))) + s;
    case (mode)
      BURST_FIXED: nxt = addr;
      BURST_WRAP:  if (nxt == base + total) nxt = base;
      default:     ;
    endcase
    return nxt;
  endfunction

  assign accept     = cmd_ready_q & bus.cmd_valid;
  assign beat_hs    = beat_valid_q & bus.beat_ready;
  assign cmd_sz     = eff_size(bus.cmd_size);
  assign cmd_s      = size_bytes(cmd_sz);
  assign cmd_total  = AW'(9'(bus.cmd_len) + 9'd1) << cmd_sz;
  assign wrap_legal = bus.cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15};
  assign nxt_addr   = next_addr(addr_q, size_q, mode_q, wrap_base_q, wrap_total_q);
  assign nxt_index  = 8'(index_q + 8'd1);

  // Reserved burst type and illegal WRAP length degrade to INCR.
  always_comb begin
    cmd_mode = BURST_INCR;
    case (bus.cmd_burst)
      2'b00:   cmd_mode = BURST_FIXED;
      2'b10:   cmd_mode = wrap_legal ? BURST_WRAP : BURST_INCR;
      default: cmd_mode = BURST_INCR;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    beat_valid_d = beat_valid_q;
    busy_d       = busy_q;
    id_d         = id_q;
    addr_d       = addr_q;
    index_d      = index_q;
    mask_d       = mask_q;
    last_d       = last_q;
    len_d        = len_q;
    size_d       = size_q;
    mode_d       = mode_q;
    wrap_base_d  = wrap_base_q;
    wrap_total_d = wrap_total_q;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          state_d      = ST_BURST;
          cmd_ready_d  = 1'b0;
          beat_valid_d = 1'b1;
          busy_d       = 1'b1;
          id_d         = bus.cmd_id;
          addr_d       = bus.cmd_addr;
          index_d      = 8'd0;
          mask_d       = lane_mask(bus.cmd_addr, cmd_sz);
          last_d       = (bus.cmd_len == 8'd0);
          len_d        = bus.cmd_len;
          size_d       = cmd_sz;
          mode_d       = cmd_mode;
          wrap_base_d  = bus.cmd_addr & ~(cmd_total - AW'(1));
          wrap_total_d = cmd_total;
        end
      end
      ST_BURST: begin
        if (beat_hs) begin
          if (last_q) begin
            state_d      = ST_IDLE;
            cmd_ready_d  = 1'b1;
            beat_valid_d = 1'b0;
            busy_d       = 1'b0;
            last_d       = 1'b0;
          end else begin
            addr_d  = nxt_addr;
            index_d = nxt_index;
            mask_d  = lane_mask(nxt_addr, size_q);
            last_d  = (nxt_index == len_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b0;
      beat_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      id_q         <= '0;
      addr_q       <= '0;
      index_q      <= '0;
      mask_q       <= '0;
      last_q       <= 1'b0;
      len_q        <= '0;
      size_q       <= '0;
      mode_q       <= '0;
      wrap_base_q  <= '0;
      wrap_total_q <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      beat_valid_q <= beat_valid_d;
      busy_q       <= busy_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      index_q      <= index_d;
      mask_q       <= mask_d;
      last_q       <= last_d;
      len_q        <= len_d;
      size_q       <= size_d;
      mode_q       <= mode_d;
      wrap_base_q  <= wrap_base_d;
      wrap_total_q <= wrap_total_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.beat_valid = beat_valid_q;
  assign bus.busy       = busy_q;
  assign bus.beat_id    = id_q;
  assign bus.beat_addr  = addr_q;
  assign bus.beat_index = index_q;
  assign bus.beat_mask  = mask_q;
  assign bus.beat_last  = last_q;

`ifdef TVIP_AXI_BURST_SEQUENCER_4KB_CHECK_EN
  logic [AW-1:0] cmd_a0;
  logic [AW:0]   cmd_end;
  logic          cross_4kb;
  logic          err_d;
  logic          err_q;

  // End address carries one extra bit so a burst past the top of memory still flags.
  assign cmd_a0    = bus.cmd_addr & ~(cmd_s - AW'(1));
  assign cmd_end   = (AW+1)'(cmd_a0) + (AW+1)'(cmd_total) - (AW+1)'(1);
  assign cross_4kb = (cmd_end[AW:12] != (AW-11)'(cmd_a0[AW-1:12]));
  assign err_d     = accept & ((bus.cmd_burst == 2'b11) ||
                               ((bus.cmd_burst == BURST_WRAP) && !wrap_legal) ||
                               ((bus.cmd_burst == BURST_INCR) && cross_4kb));

  always_ff @(posedge aclk) begin
    if (!areset_n) err_q <= 1'b0;
    else           err_q <= err_d;
  end

  assign err_4kb = err_q;
`endif
endmodule

// File: tb/tb_tvip_axi_burst_sequencer.sv
// Randomized self-checking bench for tvip_axi_burst_sequencer against a per-beat arithmetic model.
module tb_tvip_axi_burst_sequencer;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned NB = DW / 8;

  logic aclk     = 1'b0;
  logic areset_n = 1'b0;
  int   total    = 0;
  int   bad      = 0;

`ifdef TVIP_AXI_BURST_SEQUENCER_4KB_CHECK_EN
  logic err_4kb;
`endif

  tvip_axi_burst_sequencer_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  tvip_axi_burst_sequencer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .bus      (bus)
`ifdef TVIP_AXI_BURST_SEQUENCER_4KB_CHECK_EN
    ,
    .err_4kb  (err_4kb)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned eff_bytes(input int size);
    longint unsigned s;
    s = longint'(1) << size;
    if (s > NB) s = NB;
    return s;
  endfunction

  function automatic bit wrap_ok(input int len);
    return (len == 1) || (len == 3) || (len == 7) || (len == 15);
  endfunction

  // Address of beat n straight from the burst-type definitions.
  function automatic logic [31:0] exp_addr(input logic [31:0] a, input int len, input int size,
                                           input logic [1:0] burst, input int n);
    longint unsigned s, t, a0, b, av;
    av = longint'(a);
    s  = eff_bytes(size);
    a0 = av - (av % s);
    t  = s * longint'(len + 1);
    if (burst == 2'b00 || n == 0) return a;
    if (burst == 2'b10 && wrap_ok(len)) begin
      b = av - (av % t);
      return 32'(b + ((a0 - b + longint'(n) * s) % t));
    end
    return 32'(a0 + longint'(n) * s);
  endfunction

  function automatic logic [NB-1:0] exp_mask(input logic [31:0] a, input int size);
    longint unsigned s, lo, hi, av;
    logic [NB-1:0] m;
    av = longint'(a);
    s  = eff_bytes(size);
    lo = av % NB;
    hi = ((av - (av % s)) % NB) + s - 1;
    m  = '0;
    for (int i = 0; i < NB; i++) m[i] = (longint'(i) >= lo) && (longint'(i) <= hi);
    return m;
  endfunction

  function automatic bit exp_err(input logic [31:0] a, input int len, input int size,
                                 input logic [1:0] burst);
    longint unsigned s, a0;
    s  = eff_bytes(size);
    a0 = longint'(a) - (longint'(a) % s);
    if (burst == 2'b11) return 1'b1;
    if (burst == 2'b10) return !wrap_ok(len);
    if (burst == 2'b01) return (a0 / 4096) != ((a0 + s * longint'(len + 1) - 1) / 4096);
    return 1'b0;
  endfunction

  // Issue one command and consume all beats; optional 5-cycle stall at stall_beat.
  task automatic run_burst(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                           input int size, input logic [1:0] burst, input bit rand_ready,
                           input int stall_beat);
    int guard;
    int n;
    int stalls;
    bit rdy;
    bit err_e;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge aclk);
      guard++;
    end
    check_val("cmd_ready_wait", 64'(bus.cmd_ready), 64'(1));
    if (bus.cmd_ready !== 1'b1) return;
    err_e          = exp_err(addr, len, size, burst);
    bus.cmd_valid  = 1'b1;
    bus.cmd_id     = id;
    bus.cmd_addr   = addr;
    bus.cmd_len    = 8'(len);
    bus.cmd_size   = 3'(size);
    bus.cmd_burst  = burst;
    @(negedge aclk);
    bus.cmd_valid  = 1'b0;
    bus.cmd_addr   = $urandom;
    bus.cmd_len    = 8'($urandom);
    bus.cmd_id     = IW'($urandom);
    check_val("cmd_ready_busy", 64'(bus.cmd_ready), 64'(0));
    check_val("busy_on", 64'(bus.busy), 64'(1));
    n = 0;
    stalls = 0;
    guard = 0;
    while (n <= len && guard < 2000) begin
      check_val("beat_valid", 64'(bus.beat_valid), 64'(1));
      check_val("beat_addr", 64'(bus.beat_addr), 64'(exp_addr(addr, len, size, burst, n)));
      check_val("beat_mask", 64'(bus.beat_mask),
                64'(exp_mask(exp_addr(addr, len, size, burst, n), size)));
      check_val("beat_index", 64'(bus.beat_index), 64'(n));
      check_val("beat_last", 64'(bus.beat_last), 64'(n == len));
      check_val("beat_id", 64'(bus.beat_id), 64'(id));
`ifdef TVIP_AXI_BURST_SEQUENCER_4KB_CHECK_EN
      check_val("err_4kb", 64'(err_4kb), 64'((guard == 0) ? err_e : 1'b0));
`endif
      if (n == stall_beat && stalls < 5) begin
        rdy = 1'b0;
        stalls++;
      end else if (rand_ready) begin
        rdy = ($urandom_range(0, 2) != 0);
      end else begin
        rdy = 1'b1;
      end
      bus.beat_ready = rdy;
      @(negedge aclk);
      bus.beat_ready = 1'b0;
      guard++;
      if (rdy) n++;
    end
    check_val("beat_count", 64'(n), 64'(len + 1));
    check_val("idle_valid", 64'(bus.beat_valid), 64'(0));
    check_val("idle_busy", 64'(bus.busy), 64'(0));
    check_val("idle_cmd_ready", 64'(bus.cmd_ready), 64'(1));
  endtask

  initial begin
    int len;
    int size;
    logic [1:0] burst;
    logic [31:0] addr;
    int guard;

    bus.cmd_valid  = 1'b0;
    bus.cmd_id     = '0;
    bus.cmd_addr   = '0;
    bus.cmd_len    = '0;
    bus.cmd_size   = '0;
    bus.cmd_burst  = '0;
    bus.beat_ready = 1'b0;
    repeat (3) @(negedge aclk);

    check_val("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    check_val("rst_beat_valid", 64'(bus.beat_valid), 64'(0));
    check_val("rst_busy", 64'(bus.busy), 64'(0));
    check_val("rst_beat_last", 64'(bus.beat_last), 64'(0));
    check_val("rst_beat_addr", 64'(bus.beat_addr), 64'(0));
    check_val("rst_beat_index", 64'(bus.beat_index), 64'(0));
    check_val("rst_beat_mask", 64'(bus.beat_mask), 64'(0));
    check_val("rst_beat_id", 64'(bus.beat_id), 64'(0));
`ifdef TVIP_AXI_BURST_SEQUENCER_4KB_CHECK_EN
    check_val("rst_err_4kb", 64'(err_4kb), 64'(0));
`endif
    areset_n = 1'b1;
    @(negedge aclk);
    check_val("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));

    run_burst(4'h3, 32'h0000_1002, 3, 2, 2'b01, 1'b0, -1);
    run_burst(4'h5, 32'h0000_0038, 3, 2, 2'b10, 1'b0, -1);
    run_burst(4'h7, 32'h0000_0010, 2, 2, 2'b00, 1'b0, -1);
    run_burst(4'h9, 32'h0000_0001, 2, 0, 2'b01, 1'b0, -1);
    run_burst(4'hA, 32'h0000_2000, 3, 2, 2'b01, 1'b0, 1);
    run_burst(4'hB, 32'h0000_0FF8, 3, 2, 2'b01, 1'b0, -1);
    run_burst(4'hC, 32'h0000_0FF8, 1, 2, 2'b01, 1'b0, -1);
    run_burst(4'hD, 32'h0000_0101, 2, 7, 2'b01, 1'b0, -1);
    run_burst(4'hE, 32'hFFFF_FFF8, 3, 2, 2'b01, 1'b0, -1);
    run_burst(4'h1, 32'h0000_0044, 5, 2, 2'b10, 1'b0, -1);
    run_burst(4'h2, 32'h0000_0050, 0, 1, 2'b11, 1'b0, -1);

    // Abort mid-burst with reset.
    bus.cmd_valid = 1'b1;
    bus.cmd_id    = 4'h6;
    bus.cmd_addr  = 32'h0000_0400;
    bus.cmd_len   = 8'd7;
    bus.cmd_size  = 3'd2;
    bus.cmd_burst = 2'b01;
    @(negedge aclk);
    bus.cmd_valid  = 1'b0;
    bus.beat_ready = 1'b1;
    repeat (2) @(negedge aclk);
    bus.beat_ready = 1'b0;
    check_val("pre_abort_addr", 64'(bus.beat_addr), 64'(32'h0000_0408));
    areset_n = 1'b0;
    @(negedge aclk);
    check_val("abort_valid", 64'(bus.beat_valid), 64'(0));
    check_val("abort_busy", 64'(bus.busy), 64'(0));
    check_val("abort_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    check_val("abort_addr", 64'(bus.beat_addr), 64'(0));
    areset_n = 1'b1;
    @(negedge aclk);
    check_val("abort_release_ready", 64'(bus.cmd_ready), 64'(1));
    check_val("abort_release_valid", 64'(bus.beat_valid), 64'(0));

    for (int k = 0; k < 60; k++) begin
      burst = 2'($urandom_range(0, 3));
      size  = int'($urandom_range(0, 7));
      if (burst == 2'b10 && $urandom_range(0, 3) != 0) begin
        guard = int'($urandom_range(0, 3));
        len   = (2 << guard) - 1;
      end else if ($urandom_range(0, 7) == 0) begin
        len = int'($urandom_range(0, 255));
      end else begin
        len = int'($urandom_range(0, 15));
      end
      case ($urandom_range(0, 3))
        0:       addr = 32'h0000_1000 - 32'($urandom_range(0, 64));
        1:       addr = 32'hFFFF_FFFF - 32'($urandom_range(0, 64));
        default: addr = $urandom;
      endcase
      run_burst(IW'($urandom), addr, len, size, burst, 1'b1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
